// File: rtl/train_step_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : train_step_driver_pkg
// Description : Shared FSM state encoding, controller state codes and helpers
//               for the train step driver.
// Revision    : 1.0 - initial release
// ============================================================================
package train_step_driver_pkg;

    // Driver FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADVANCE = 3'd1,
        ST_DWELL   = 3'd2,
        ST_RETURN  = 3'd3,
        ST_FAULT   = 3'd4
    } fsm_state_t;

    // Train controller counter codes
    localparam logic [3:0] S_HOME  = 4'b0000;
    localparam logic [3:0] S_STN_A = 4'b0110;
    localparam logic [3:0] S_STN_B = 4'b0111;
    localparam logic [3:0] S_END_A = 4'b1110;
    localparam logic [3:0] S_END_B = 4'b1111;

    // True when the controller is parked at the station (either loop code)
    function automatic logic is_station(input logic [3:0] code);
        return (code == S_STN_A) || (code == S_STN_B);
    endfunction

    // True when the controller has reached the end of the line
    function automatic logic is_end(input logic [3:0] code);
        return (code == S_END_A) || (code == S_END_B);
    endfunction

endpackage : train_step_driver_pkg
`default_nettype wire

// File: rtl/train_step_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : train_step_driver_if
// Description : Operator/controller-side signal bundle of the step driver.
//               master = the driver, slave = operator panel + controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface train_step_driver_if;

    logic       start_btn;
    logic       sensor;
    logic [3:0] present_state;
    logic       en;
    logic       y;
    logic       busy;
    logic       fault;
    logic [7:0] trip_cnt;

    modport master (
        input  start_btn,
        input  sensor,
        input  present_state,
        input  en,
        output y,
        output busy,
        output fault,
        output trip_cnt
    );

    modport slave (
        output start_btn,
        output sensor,
        output present_state,
        output en,
        input  y,
        input  busy,
        input  fault,
        input  trip_cnt
    );

endinterface : train_step_driver_if
`default_nettype wire

// File: rtl/train_step_driver_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : 2-flop synchronizer followed by a counter debouncer. The
//               output follows the synchronized input only after DEB_CYCLES
//               consecutive samples that differ from the current output.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      dout
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q,   deb_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Synchronize, then count consecutive samples disagreeing with the output
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Register synchronizer stages, counter and debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule : input_debounce
`default_nettype wire

// File: rtl/train_step_driver.sv
`default_nettype none
// ============================================================================
// Module      : train_step_driver
// Description : Drives the y step request of a 4-bit train controller through
//               one trip: home -> station dwell -> end of line -> home, with
//               debounced operator inputs, ack timeout and sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module train_step_driver
    import train_step_driver_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    train_step_driver_if.master bus
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic start_deb;
    logic sensor_deb;

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.start_btn),
        .dout (start_deb)
    );

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sensor_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sensor),
        .dout (sensor_deb)
    );

    fsm_state_t        state_q,      state_d;
    logic [3:0]        prev_state_q, prev_state_d;
    logic              start_prev_q, start_prev_d;
    logic              sensor_ok_q,  sensor_ok_d;
    logic [DW_W-1:0]   dwell_cnt_q,  dwell_cnt_d;
    logic [TO_W-1:0]   tmo_q,        tmo_d;
    logic [7:0]        trip_cnt_q,   trip_cnt_d;
    logic              y_q,          y_d;
    logic              busy_q,       busy_d;
    logic              fault_q,      fault_d;

    logic start_req;
    logic ack;
    logic timed_state;
    logic tmo_hit;
    logic arrive_station;
    logic fault_cond;

    // Next-state, counters and registered Moore outputs
    always_comb begin
        start_req    = start_deb & ~start_prev_q;
        ack          = (bus.present_state != prev_state_q);
        timed_state  = (state_q == ST_ADVANCE) || (state_q == ST_RETURN);
        tmo_hit      = timed_state && !ack && (tmo_q == TO_W'(ACK_TIMEOUT - 1));
        // Only a fresh arrival at the station starts a dwell; leaving the
        // dwell while still on 0110/0111 must not re-enter it.
        arrive_station = is_station(bus.present_state) && !is_station(prev_state_q);
        fault_cond   = (bus.en && (state_q != ST_ADVANCE)) || tmo_hit;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = (bus.present_state == S_HOME) ? ST_ADVANCE : ST_FAULT;
                end
            end
            ST_ADVANCE: begin
                if (arrive_station) begin
                    state_d = ST_DWELL;
                end else if (is_end(bus.present_state)) begin
                    state_d = ST_RETURN;
                end
            end
            ST_DWELL: begin
                if (!is_station(bus.present_state)) begin
                    state_d = ST_FAULT;
                end else if ((dwell_cnt_q == DW_W'(DWELL_CYCLES)) && sensor_ok_q) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_RETURN: begin
                if (bus.present_state == S_HOME) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
        // Fault conditions override any normal transition
        if (fault_cond) begin
            state_d = ST_FAULT;
        end

        prev_state_d = bus.present_state;
        start_prev_d = start_deb;

        if ((state_q == ST_DWELL) && (state_d == ST_ADVANCE)) begin
            sensor_ok_d = 1'b0;
        end else begin
            sensor_ok_d = sensor_ok_q | sensor_deb;
        end

        if (state_q != ST_DWELL) begin
            dwell_cnt_d = '0;
        end else if (dwell_cnt_q != DW_W'(DWELL_CYCLES)) begin
            dwell_cnt_d = dwell_cnt_q + DW_W'(1);
        end else begin
            dwell_cnt_d = dwell_cnt_q;
        end

        if (ack || (state_d != state_q) || !timed_state) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TO_W'(1);
        end

        trip_cnt_d = trip_cnt_q;
        if ((state_q == ST_RETURN) && (state_d == ST_IDLE)) begin
            trip_cnt_d = trip_cnt_q + 8'd1;
        end

        y_d     = (state_d == ST_ADVANCE);
        busy_d  = (state_d == ST_ADVANCE) || (state_d == ST_DWELL) || (state_d == ST_RETURN);
        fault_d = (state_d == ST_FAULT);
    end

    // FSM state, bookkeeping registers and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_state_q <= 4'd0;
            start_prev_q <= 1'b0;
            sensor_ok_q  <= 1'b0;
            dwell_cnt_q  <= '0;
            tmo_q        <= '0;
            trip_cnt_q   <= 8'd0;
            y_q          <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= prev_state_d;
            start_prev_q <= start_prev_d;
            sensor_ok_q  <= sensor_ok_d;
            dwell_cnt_q  <= dwell_cnt_d;
            tmo_q        <= tmo_d;
            trip_cnt_q   <= trip_cnt_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.y        = y_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.trip_cnt = trip_cnt_q;

endmodule : train_step_driver
`default_nettype wire

// File: tb/tb_train_step_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_train_step_driver
// Description : Directed self-checking bench for train_step_driver with a
//               behavioural train controller model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_train_step_driver;
    import train_step_driver_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic freeze;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;

    always #5 clk = ~clk;

    train_step_driver_if bus ();

    train_step_driver #(
        .DEB_CYCLES   (4),
        .DWELL_CYCLES (8),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; the controller model then reacts to the new y.
    // y=1 steps the counter, y=0 loops at the station or returns from the end.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!freeze) begin
            bus.en = 1'b0;
            if (bus.y === 1'b1) begin
                if (bus.present_state == S_HOME) bus.en = 1'b1;
                bus.present_state = bus.present_state + 4'd1;
            end else if (bus.present_state == S_STN_A) begin
                bus.present_state = S_STN_B;
            end else if (bus.present_state == S_STN_B) begin
                bus.present_state = S_STN_A;
            end else if (bus.present_state == S_END_A || bus.present_state == S_END_B) begin
                bus.present_state = S_HOME;
            end
        end
    endtask

    task automatic wait_y(input logic v, input int bound, input string tag);
        int k = 0;
        while (bus.y !== v && k < bound) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, bus.y}, {31'd0, v});
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k = 0;
        while (bus.busy !== 1'b0 && k < bound) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        freeze            = 1'b0;
        bus.en            = 1'b0;
        bus.start_btn     = 1'b0;
        bus.present_state = S_HOME;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_trip();
        bus.start_btn = 1'b1;
        wait_y(1'b1, 20, "trip_start");
        bus.start_btn = 1'b0;
        wait_idle(200, "trip_end");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        freeze            = 1'b0;
        rst               = 1'b1;
        bus.start_btn     = 1'b0;
        bus.sensor        = 1'b1;
        bus.en            = 1'b0;
        bus.present_state = S_HOME;

        // ---- Test 1: full trip with sensor already high ----
        do_reset();
        chk("rst_y",     {31'd0, bus.y},     32'd0);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_trip",  {24'd0, bus.trip_cnt}, 32'd0);

        // 2 sync + 4 debounce edges, then one edge for the FSM
        bus.start_btn = 1'b1;
        repeat (6) tick();
        chk("t1_y_pre_start", {31'd0, bus.y}, 32'd0);
        tick();
        chk("t1_y_advance", {31'd0, bus.y},    32'd1);
        chk("t1_busy",      {31'd0, bus.busy}, 32'd1);
        repeat (3) tick();
        bus.start_btn = 1'b0;

        wait_y(1'b0, 30, "t1_dwell_entry");
        chk("t1_at_station", {29'd0, bus.present_state[3:1]}, 32'd3);
        // Counter runs 0..8 in DWELL, exit on the edge after it holds 8
        n = 0;
        while (bus.y === 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk("t1_dwell_len", n, 32'd9);

        wait_y(1'b0, 30, "t1_return");
        chk("t1_home",     {28'd0, bus.present_state}, 32'd0);
        chk("t1_busy_ret", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("t1_busy_fall", {31'd0, bus.busy},     32'd0);
        chk("t1_trip",      {24'd0, bus.trip_cnt}, 32'd1);
        chk("t1_no_fault",  {31'd0, bus.fault},    32'd0);

        // ---- Test 2: bouncing start shorter than the debounce window ----
        repeat (8) tick();
        bus.start_btn = 1'b1; repeat (2) tick();
        bus.start_btn = 1'b0; repeat (2) tick();
        bus.start_btn = 1'b1; repeat (2) tick();
        bus.start_btn = 1'b0;
        repeat (14) tick();
        chk("t2_y",    {31'd0, bus.y},    32'd0);
        chk("t2_busy", {31'd0, bus.busy}, 32'd0);

        // ---- Test 3: controller freezes at 0011 while advancing ----
        bus.start_btn = 1'b1;
        wait_y(1'b1, 20, "t3_start");
        bus.start_btn = 1'b0;
        n = 0;
        while (bus.present_state != 4'b0011 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_reach_0011", {28'd0, bus.present_state}, 32'd3);
        freeze = 1'b1;
        repeat (16) tick();
        chk("t3_no_fault_15", {31'd0, bus.fault}, 32'd0);
        chk("t3_y_still_1",   {31'd0, bus.y},     32'd1);
        tick();
        chk("t3_fault_16", {31'd0, bus.fault}, 32'd1);
        chk("t3_y_0",      {31'd0, bus.y},     32'd0);
        chk("t3_busy_0",   {31'd0, bus.busy},  32'd0);
        do_reset();
        chk("t3_fault_clr", {31'd0, bus.fault}, 32'd0);

        // ---- Test 5: en in IDLE faults; start ignored until rst ----
        freeze = 1'b1;
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
        chk("t5_fault", {31'd0, bus.fault}, 32'd1);
        chk("t5_busy",  {31'd0, bus.busy},  32'd0);
        bus.start_btn = 1'b1;
        repeat (10) tick();
        chk("t5_y_ignored", {31'd0, bus.y},     32'd0);
        chk("t5_sticky",    {31'd0, bus.fault}, 32'd1);
        bus.start_btn = 1'b0;
        repeat (8) tick();
        do_reset();
        chk("t5_fault_rst", {31'd0, bus.fault}, 32'd0);

        // ---- Test 4: sensor rises at dwell entry; exit on count 8 ----
        bus.sensor = 1'b0;
        do_reset();
        bus.start_btn = 1'b1;
        wait_y(1'b1, 20, "t4_start");
        bus.start_btn = 1'b0;
        wait_y(1'b0, 30, "t4_dwell_entry");
        bus.sensor = 1'b1;
        n = 0;
        while (bus.y === 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk("t4_dwell_len", n, 32'd9);
        bus.sensor = 1'b0;
        wait_idle(100, "t4_idle");
        chk("t4_trip", {24'd0, bus.trip_cnt}, 32'd1);

        // ---- Test 6: 256 trips wrap the counter; rst mid-advance ----
        bus.sensor = 1'b1;
        do_reset();
        for (int i = 0; i < 255; i++) do_trip();
        chk("t6_trip_255", {24'd0, bus.trip_cnt}, 32'd255);
        do_trip();
        chk("t6_trip_wrap", {24'd0, bus.trip_cnt}, 32'd0);
        repeat (8) tick();
        bus.start_btn = 1'b1;
        wait_y(1'b1, 20, "t6_start");
        bus.start_btn = 1'b0;
        tick();
        tick();
        chk("t6_y_adv", {31'd0, bus.y}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_y",    {31'd0, bus.y},        32'd0);
        chk("t6_rst_busy", {31'd0, bus.busy},     32'd0);
        chk("t6_rst_trip", {24'd0, bus.trip_cnt}, 32'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_train_step_driver
`default_nettype wire

// File: doc/train_step_driver.md
TRAIN_STEP_DRIVER -- requirements
Module: train_step_driver

Interface
REQ-001 Parameter DEB_CYCLES, default 4: cycles an input must hold stable before its debounced value updates.
REQ-002 Parameter DWELL_CYCLES, default 8: minimum y=0 dwell time at the station states 0110/0111.
REQ-003 Parameter ACK_TIMEOUT, default 16: cycles without a present_state change before a fault is declared.
REQ-004 clk  input  1  single clock; all logic samples on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start_btn  input  1  raw start request from the operator, asynchronous and bouncy.
REQ-007 sensor  input  1  raw station-departure clearance, asynchronous and bouncy.
REQ-008 present_state  input  4  state code from the train controller counter.
REQ-009 en  input  1  departure strobe from the controller, high on the 0000->0001 step.
REQ-010 y  output  1  step request to the controller: 1 = advance, 0 = hold/loop/return.
REQ-011 busy  output  1  high in every state except IDLE and FAULT.
REQ-012 fault  output  1  sticky protocol-fault flag.
REQ-013 trip_cnt  output  8  count of completed trips.

Function
REQ-014 Both raw inputs SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced value SHALL change only after DEB_CYCLES consecutive equal synchronized samples.
REQ-015 start_req SHALL be a one-cycle pulse on the debounced start_btn rising edge.
REQ-016 sensor_ok SHALL be latched on the debounced sensor level; the latch SHALL clear on DWELL exit.
REQ-017 prev_state SHALL register present_state every cycle; ack = (present_state != prev_state).
REQ-018 FSM states: IDLE, ADVANCE, DWELL, RETURN, FAULT; y is a registered Moore output.
REQ-019 IDLE: y=0. Go to ADVANCE on start_req with present_state==0000. start_req with any other present_state SHALL go to FAULT.
REQ-020 ADVANCE: y=1. Go to DWELL when present_state is 0110 or 0111. Go to RETURN when present_state is 1110 or 1111.
REQ-021 DWELL: y=0. The dwell counter SHALL load 0 on entry and saturate at DWELL_CYCLES. Go to ADVANCE when the counter equals DWELL_CYCLES and sensor_ok=1.
REQ-022 In DWELL, the controller's 0110<->0111 toggling counts as ack. A present_state outside {0110,0111} SHALL go to FAULT.
REQ-023 RETURN: y=0. Go to IDLE when present_state==0000, incrementing trip_cnt by 1 (wrapping 255->0).
REQ-024 The timeout counter SHALL clear on ack or on a state change and increment otherwise in ADVANCE and RETURN. When it reaches ACK_TIMEOUT, go to FAULT.
REQ-025 en=1 in any state other than ADVANCE SHALL go to FAULT.
REQ-026 FAULT: y=0, fault=1, busy=0. FAULT SHALL be exited only by rst.
REQ-027 start_req while busy SHALL be ignored.
REQ-028 When a fault condition and a normal transition occur in the same cycle, FAULT SHALL win.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL take these values on the next cycle: state=IDLE, y=0, busy=0, fault=0, trip_cnt=0, all counters and latches 0, synchronizers and debounced values 0.
REQ-030 rst asserted mid-trip SHALL drop y within one cycle and SHALL NOT increment trip_cnt.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the controller state-code constants: S_HOME=0000, S_STN_A=0110, S_STN_B=0111, S_END_A=1110, S_END_B=1111.
REQ-032 Synchronizer plus debouncer SHALL be one sub-module, input_debounce, parameterized by DEB_CYCLES and instantiated twice.

Verification
REQ-033 Test 1: rst, then start_btn high for 10 cycles, with the controller model attached -> y=1 until state 0110; y=0 for at least 8 cycles; with sensor high -> advance to 1110; return to 0000; trip_cnt=1; busy falls.
REQ-034 Test 2: start_btn bouncing 1-0-1 with 2-cycle pulses (below DEB_CYCLES=4) -> no start_req and y stays 0.
REQ-035 Test 3: controller model frozen at 0011 while y=1 -> fault=1 exactly 16 cycles after the last change; y=0.
REQ-036 Test 4: sensor high before the dwell expires -> leave DWELL exactly on dwell count 8, not earlier.
REQ-037 Test 5: en forced high in IDLE -> FAULT; a later start_btn is ignored until rst.
REQ-038 Test 6: 256 complete trips -> trip_cnt wraps to 0; rst during ADVANCE -> y=0 on the next cycle and trip_cnt unchanged.
